// File: rtl/onehot_decoder_pkg.sv
// Shared types for the one-hot decoder pipeline: occupancy state and error-counter width.
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int ERRCNT_W = 8;

endpackage

// File: rtl/onehot_decode_comb.sv
// Combinational code-to-vector decoder; codes at or above OUT_N give an all-inactive vector and err.
module onehot_decode_comb #(
  parameter int IN_W       = 4,
  parameter int OUT_N      = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_N-1:0] vec,
  output logic             err
);

  logic [OUT_N-1:0] hot;

  always_comb begin
    hot = '0;
    for (int i = 0; i < OUT_N; i++) begin
      if (code == IN_W'(i)) hot[i] = 1'b1;
    end
    // No bit set means the code had no matching output.
    err = ~|hot;
    vec = (ACTIVE_LOW != 0) ? ~hot : hot;
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered one-hot/one-cold decoder with a 2-entry output/skid buffer and valid/ready handshakes.
// Optional saturating out-of-range counter on err_cnt when ONEHOT_DECODER_ERRCNT_EN is defined.
//
// state | meaning
// EMPTY | no result held, out_valid low
// ONE   | output register holds a result
// TWO   | output and skid registers both full, input stalled
module onehot_decoder_pipe
  import onehot_decoder_pkg::*;
#(
  parameter int IN_W       = 4,
  parameter int OUT_N      = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  pi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] po,
  output logic             out_err
`ifdef ONEHOT_DECODER_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam logic [OUT_N-1:0] IDLE_VEC = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

  state_e           state_q, state_d;
  logic [OUT_N-1:0] out_vec_q, out_vec_d;
  logic [OUT_N-1:0] skid_vec_q, skid_vec_d;
  logic             out_err_q, out_err_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_N-1:0] dec_vec;
  logic             dec_err;
  logic             in_xfer;
  logic             out_xfer;

  onehot_decode_comb #(
    .IN_W      (IN_W),
    .OUT_N     (OUT_N),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_decode (
    .code(pi),
    .vec (dec_vec),
    .err (dec_err)
  );

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = (state_q != EMPTY) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign po        = out_vec_q;
  assign out_err   = out_err_q;

  always_comb begin
    state_d    = state_q;
    out_vec_d  = out_vec_q;
    out_err_d  = out_err_q;
    skid_vec_d = skid_vec_q;
    skid_err_d = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          out_vec_d = dec_vec;
          out_err_d = dec_err;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_vec_d = dec_vec;
          out_err_d = dec_err;
        end else if (in_xfer) begin
          skid_vec_d = dec_vec;
          skid_err_d = dec_err;
          state_d    = TWO;
        end else if (out_xfer) begin
          // Park the output register at idle so po is inactive while empty.
          out_vec_d = IDLE_VEC;
          out_err_d = 1'b0;
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          out_vec_d  = skid_vec_q;
          out_err_d  = skid_err_q;
          skid_vec_d = IDLE_VEC;
          skid_err_d = 1'b0;
          state_d    = ONE;
        end
      end
      default: begin
        out_vec_d  = IDLE_VEC;
        out_err_d  = 1'b0;
        skid_vec_d = IDLE_VEC;
        skid_err_d = 1'b0;
        state_d    = EMPTY;
      end
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_vec_q  <= IDLE_VEC;
      out_err_q  <= 1'b0;
      skid_vec_q <= IDLE_VEC;
      skid_err_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_vec_q  <= out_vec_d;
      out_err_q  <= out_err_d;
      skid_vec_q <= skid_vec_d;
      skid_err_q <= skid_err_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef ONEHOT_DECODER_ERRCNT_EN
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = {ERRCNT_W{1'b1}};

  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && dec_err && (err_cnt_q != ERRCNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
